branch_predictor: RTL and testbench

//  Bimodal branch direction predictor for the fetch stage; receives the cmp_to_IF update

---
 rtl/branch_predictor.sv | 116 +++++++++++
 tb/tb_branch_predictor.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Bimodal 64x2-bit branch predictor: combinational (0-cycle) lookup; updates land at the clock edge.
// The compare-unit stream is never back-pressured: updates during reset or the init walk are dropped.
module branch_predictor #(
  parameter int unsigned IDX_W    = 6,
  parameter logic [1:0]  CTR_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pred_pc,
  input  logic        pred_is_branch,
  input  logic [31:0] pred_imm,
  output logic        pred_ready,
  output logic        pred_taken,
  output logic [31:0] pred_pc_next,
  input  logic [33:0] cmp_in,
  output logic [31:0] upd_count
);

  localparam int unsigned N_ENT = 1 << IDX_W;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  typedef struct packed {
    logic        we;
    logic        taken;
    logic [31:0] pc;
  } cmp_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;
  logic [31:0]      upd_count_q, upd_count_d;
  logic             pred_ready_q, pred_ready_d;

  // No reset on the table: the init walk is the only way it gets defined contents.
  logic [1:0]       ctr_q [N_ENT];

  cmp_t             cmp;
  logic             upd_acc;
  logic [IDX_W-1:0] upd_idx;
  logic [1:0]       upd_old, upd_new;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_widx;
  logic [1:0]       tbl_wdat;
  logic [IDX_W-1:0] lk_idx;
  logic [1:0]       lk_ctr;

  always_comb begin
    cmp     = cmp_t'(cmp_in);
    upd_idx = cmp.pc[IDX_W+1:2];
    upd_old = ctr_q[upd_idx];
    upd_acc = (state_q == ST_RUN) && cmp.we && (cmp.pc != 32'd0);
    upd_new = upd_old;
    if (cmp.taken) begin
      if (upd_old != 2'b11) upd_new = upd_old + 2'b01;
    end else begin
      if (upd_old != 2'b00) upd_new = upd_old - 2'b01;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    upd_count_d = upd_count_q;
    case (state_q)
      ST_INIT: begin
        init_idx_d = init_idx_q + IDX_W'(1);
        if (&init_idx_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (upd_acc) upd_count_d = upd_count_q + 32'd1;
      end
      default: state_d = ST_INIT;
    endcase
    pred_ready_d = (state_d == ST_RUN);
  end

  always_comb begin
    tbl_we   = !rst && ((state_q == ST_INIT) || upd_acc);
    tbl_widx = (state_q == ST_INIT) ? init_idx_q : upd_idx;
    tbl_wdat = (state_q == ST_INIT) ? CTR_INIT : upd_new;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      init_idx_q   <= '0;
      upd_count_q  <= '0;
      pred_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      upd_count_q  <= upd_count_d;
      pred_ready_q <= pred_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_we) ctr_q[tbl_widx] <= tbl_wdat;
  end

  // Lookup reads the pre-update counter; a same-cycle write is seen next cycle.
  always_comb begin
    lk_idx       = pred_pc[IDX_W+1:2];
    lk_ctr       = ctr_q[lk_idx];
    pred_taken   = 1'b0;
    pred_pc_next = pred_pc + 32'd4;
    if (pred_ready_q && pred_is_branch && lk_ctr[1]) begin
      pred_taken   = 1'b1;
      pred_pc_next = pred_pc + pred_imm;
    end
  end

  assign pred_ready = pred_ready_q;
  assign upd_count  = upd_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] pred_pc;
  logic        pred_is_branch;
  logic [31:0] pred_imm;
  logic        pred_ready;
  logic        pred_taken;
  logic [31:0] pred_pc_next;
  logic [33:0] cmp_in;
  logic [31:0] upd_count;

  int n_checks = 0;
  int n_errors = 0;

  branch_predictor dut (
    .clk           (clk),
    .rst           (rst),
    .pred_pc       (pred_pc),
    .pred_is_branch(pred_is_branch),
    .pred_imm      (pred_imm),
    .pred_ready    (pred_ready),
    .pred_taken    (pred_taken),
    .pred_pc_next  (pred_pc_next),
    .cmp_in        (cmp_in),
    .upd_count     (upd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic lookup(input logic [31:0] pc, input logic [31:0] imm, input logic br);
    pred_pc        = pc;
    pred_imm       = imm;
    pred_is_branch = br;
    #1;
  endtask

  task automatic update(input logic we, input logic taken, input logic [31:0] pc);
    cmp_in = {we, taken, pc};
    tick();
    cmp_in = '0;
  endtask

  initial begin
    rst            = 1'b1;
    cmp_in         = '0;
    pred_pc        = '0;
    pred_imm       = '0;
    pred_is_branch = 1'b0;
    ticks(2);
    chk("rst_ready", {31'd0, pred_ready}, 32'd0);
    chk("rst_count", upd_count, 32'd0);

    // 1: init walk takes exactly 64 cycles after release
    rst = 1'b0;
    ticks(63);
    chk("init_ready_63", {31'd0, pred_ready}, 32'd0);
    lookup(32'h6000_0010, 32'h20, 1'b1);
    chk("init_taken", {31'd0, pred_taken}, 32'd0);
    chk("init_next", pred_pc_next, 32'h6000_0014);
    tick();
    chk("init_ready_64", {31'd0, pred_ready}, 32'd1);
    lookup(32'h6000_0010, 32'h20, 1'b1);
    chk("t1_taken", {31'd0, pred_taken}, 32'd0);
    chk("t1_next", pred_pc_next, 32'h6000_0014);

    // 2: two taken updates, 01 -> 11
    update(1'b1, 1'b1, 32'h6000_0010);
    update(1'b1, 1'b1, 32'h6000_0010);
    lookup(32'h6000_0010, 32'h20, 1'b1);
    chk("t2_taken", {31'd0, pred_taken}, 32'd1);
    chk("t2_next", pred_pc_next, 32'h6000_0030);
    chk("t2_count", upd_count, 32'd2);

    // 3: saturation at 11, then hysteresis down
    for (int i = 0; i < 5; i++) update(1'b1, 1'b1, 32'h6000_0020);
    update(1'b1, 1'b0, 32'h6000_0020);
    lookup(32'h6000_0020, 32'h100, 1'b1);
    chk("t3_nt1_taken", {31'd0, pred_taken}, 32'd1);
    chk("t3_nt1_next", pred_pc_next, 32'h6000_0120);
    update(1'b1, 1'b0, 32'h6000_0020);
    lookup(32'h6000_0020, 32'h100, 1'b1);
    chk("t3_nt2_taken", {31'd0, pred_taken}, 32'd0);
    chk("t3_nt2_next", pred_pc_next, 32'h6000_0024);
    chk("t3_count", upd_count, 32'd9);

    // 4: aliasing and rejected updates
    update(1'b1, 1'b1, 32'h0000_0100);
    update(1'b1, 1'b1, 32'h0000_0100);
    lookup(32'h0000_0200, 32'h40, 1'b1);
    chk("t4_alias_taken", {31'd0, pred_taken}, 32'd1);
    chk("t4_alias_next", pred_pc_next, 32'h0000_0240);
    lookup(32'h0000_0104, 32'h40, 1'b1);
    chk("t4_neigh_taken", {31'd0, pred_taken}, 32'd0);
    chk("t4_neigh_next", pred_pc_next, 32'h0000_0108);
    update(1'b1, 1'b0, 32'h0000_0000);
    update(1'b1, 1'b0, 32'h0000_0000);
    update(1'b0, 1'b0, 32'h0000_0100);
    update(1'b0, 1'b0, 32'h0000_0100);
    lookup(32'h0000_0100, 32'h40, 1'b1);
    chk("t4_drop_taken", {31'd0, pred_taken}, 32'd1);
    chk("t4_drop_count", upd_count, 32'd11);
    lookup(32'h0000_0100, 32'h40, 1'b0);
    chk("t4_nonbr_taken", {31'd0, pred_taken}, 32'd0);
    chk("t4_nonbr_next", pred_pc_next, 32'h0000_0104);
    lookup(32'hFFFF_FFFC, 32'h40, 1'b0);
    chk("t4_wrap_next", pred_pc_next, 32'h0000_0000);

    // 5: same-cycle update and lookup: no bypass
    cmp_in = {1'b1, 1'b1, 32'h6000_0040};
    lookup(32'h6000_0040, 32'h80, 1'b1);
    chk("t5_same_taken", {31'd0, pred_taken}, 32'd0);
    chk("t5_same_next", pred_pc_next, 32'h6000_0044);
    tick();
    cmp_in = '0;
    lookup(32'h6000_0040, 32'h80, 1'b1);
    chk("t5_next_taken", {31'd0, pred_taken}, 32'd1);
    chk("t5_next_next", pred_pc_next, 32'h6000_00C0);
    chk("t5_count", upd_count, 32'd12);

    // 6: reset mid-RUN re-walks the table and drops updates meanwhile
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_ready", {31'd0, pred_ready}, 32'd0);
    chk("t6_rst_count", upd_count, 32'd0);
    cmp_in = {1'b1, 1'b1, 32'h6000_0010};
    ticks(63);
    cmp_in = '0;
    chk("t6_ready_63", {31'd0, pred_ready}, 32'd0);
    tick();
    chk("t6_ready_64", {31'd0, pred_ready}, 32'd1);
    chk("t6_count", upd_count, 32'd0);
    lookup(32'h6000_0010, 32'h20, 1'b1);
    chk("t6_taken", {31'd0, pred_taken}, 32'd0);
    chk("t6_next", pred_pc_next, 32'h6000_0014);
    update(1'b1, 1'b1, 32'h6000_0010);
    lookup(32'h6000_0010, 32'h20, 1'b1);
    chk("t6_one_up_taken", {31'd0, pred_taken}, 32'd1);
    chk("t6_one_up_count", upd_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
